// File: rtl/daq_spi_pkg.sv
`default_nettype none
// ============================================================================
// Module      : daq_spi_pkg
// Description : Word-layout constants and serial helpers shared by the
//               DAQ SPI front end (frame sequencer, DAC and ADC lanes).
// Revision    : 1.0 - initial release
// ============================================================================
package daq_spi_pkg;

  localparam int DAC_PAD_W      = 2;   // trailing zero pad of a DAC word
  localparam int ADC_LEAD_ZEROS = 4;   // leading zero bits of an ADC reading
  localparam int DATA_W         = 12;  // sample width for DAC and ADC
  localparam int CNT_W          = 6;   // frame phase counter width
  localparam int WORD_W         = DATA_W + ADC_LEAD_ZEROS;  // 16-bit SPI word
  localparam int ADC_CH_W       = 3;

  // DAC command word: power-down code, sample, zero pad
  function automatic logic [WORD_W-1:0] dac_word(input logic [1:0]        pd,
                                                  input logic [DATA_W-1:0] data);
    dac_word = {pd, data, {DAC_PAD_W{1'b0}}};
  endfunction

  // ADC control word: channel address in bits 13..11, everything else zero
  function automatic logic [WORD_W-1:0] adc_word(input logic [ADC_CH_W-1:0] ch);
    adc_word = {2'b00, ch, 11'b0};
  endfunction

  // Bit presented on a mosi line for a given frame phase: MSB first over
  // phases 2..P-1, two phases per bit, and 0 outside the bit phases
  function automatic logic serial_bit(input logic [WORD_W-1:0] word,
                                      input logic [CNT_W-1:0]  cnt);
    logic [CNT_W-1:0] b;
    b          = (cnt - CNT_W'(2)) >> 1;
    serial_bit = 1'b0;
    if (cnt >= CNT_W'(2) && b < CNT_W'(WORD_W)) begin
      serial_bit = word[4'd15 - b[3:0]];
    end
  endfunction

endpackage
`default_nettype wire

// File: rtl/daq_spi_frontend_if.sv
`default_nettype none
// ============================================================================
// Module      : daq_spi_frontend_if
// Description : Bus bundle between the DAQ SPI front end (master side) and
//               its user logic / converter pins (slave side).
// Revision    : 1.0 - initial release
// ============================================================================
interface daq_spi_frontend_if;
  import daq_spi_pkg::*;

  logic                ss;
  logic                sclk;
  logic                dac_sclk;
  logic                ready;
  logic [CNT_W-1:0]    cnt;
  logic [1:0]          dac_pd;
  logic [DATA_W-1:0]   dac_data_a;
  logic [DATA_W-1:0]   dac_data_b;
  logic                dac_mosi_a;
  logic                dac_mosi_b;
  logic [ADC_CH_W-1:0] adc_channel;
  logic                adc_miso_a;
  logic                adc_miso_b;
  logic                adc_mosi_a;
  logic                adc_mosi_b;
  logic [DATA_W-1:0]   adc_data_a;
  logic [DATA_W-1:0]   adc_data_b;

  modport master (
    output ss, sclk, dac_sclk, ready, cnt,
    output dac_mosi_a, dac_mosi_b, adc_mosi_a, adc_mosi_b,
    output adc_data_a, adc_data_b,
    input  dac_pd, dac_data_a, dac_data_b, adc_channel, adc_miso_a, adc_miso_b
  );

  modport slave (
    input  ss, sclk, dac_sclk, ready, cnt,
    input  dac_mosi_a, dac_mosi_b, adc_mosi_a, adc_mosi_b,
    input  adc_data_a, adc_data_b,
    output dac_pd, dac_data_a, dac_data_b, adc_channel, adc_miso_a, adc_miso_b
  );

endinterface
`default_nettype wire

// File: rtl/daq_spi_frontend_seq.sv
`default_nettype none
// ============================================================================
// Module      : spi_frame_seq
// Description : Free-running frame sequencer: phase counter, ready strobe,
//               shared chip select and ADC serial clock.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_frame_seq
  import daq_spi_pkg::*;
#(
  parameter logic CPOL  = 1'b1,
  parameter logic SS    = 1'b1,
  parameter int   BYTES = 2
) (
  input  logic             clk,
  input  logic             reset,
  output logic [CNT_W-1:0] cnt,
  output logic             ready,
  output logic             ss,
  output logic             sclk
);

  localparam int               PERIOD   = 16 * BYTES + 2;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(PERIOD - 1);

  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W-1:0] cnt_q;

  // Next phase: count up through the frame and wrap at the last phase
  always_comb begin
    cnt_d = (cnt_q == LAST_CNT) ? '0 : cnt_q + CNT_W'(1);
  end

  // Phase counter register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Decode strobes: phase 0 is the idle gap, bits toggle sclk on odd phases
  always_comb begin
    cnt   = cnt_q;
    ready = (cnt_q == '0) && !reset;
    ss    = (cnt_q == '0) ? SS : ~SS;
    sclk  = (cnt_q >= CNT_W'(2) && cnt_q[0]) ? ~CPOL : CPOL;
  end

endmodule
`default_nettype wire

// File: rtl/daq_spi_frontend_ser.sv
`default_nettype none
// ============================================================================
// Module      : spi_dac_ser / spi_adc_ser
// Description : Per-converter serial lanes driven by the shared frame phase.
//               DAC lane shifts out a command word; ADC lane shifts out its
//               channel word and collects the conversion result.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_dac_ser
  import daq_spi_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [CNT_W-1:0]  cnt,
  input  logic [1:0]        pd,
  input  logic [DATA_W-1:0] data,
  output logic              mosi
);

  logic [WORD_W-1:0] word_d;
  logic [WORD_W-1:0] word_q;

  // Take a fresh command word only at the frame boundary
  always_comb begin
    word_d = (cnt == '0) ? dac_word(pd, data) : word_q;
  end

  // Captured frame word
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      word_q <= '0;
    end else begin
      word_q <= word_d;
    end
  end

  // Serial data straight from the phase counter and captured word
  always_comb begin
    mosi = serial_bit(word_q, cnt);
  end

endmodule

module spi_adc_ser
  import daq_spi_pkg::*;
#(
  parameter int BYTES = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [CNT_W-1:0]    cnt,
  input  logic [ADC_CH_W-1:0] channel,
  input  logic                miso,
  output logic                mosi,
  output logic [DATA_W-1:0]   data
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(16 * BYTES + 1);

  logic [WORD_W-1:0] word_d;
  logic [WORD_W-1:0] word_q;
  logic [WORD_W-1:0] shift_d;
  logic [WORD_W-1:0] shift_q;
  logic [DATA_W-1:0] data_d;
  logic [DATA_W-1:0] data_q;
  logic              unused_shift_msbs;

  // Capture channel word at frame start; sample miso at the end of each bit;
  // publish the result including the bit sampled on the frame's last edge
  always_comb begin
    word_d  = (cnt == '0) ? adc_word(channel) : word_q;
    shift_d = cnt[0] ? {shift_q[WORD_W-2:0], miso} : shift_q;
    data_d  = (cnt == LAST_CNT) ? shift_d[DATA_W-1:0] : data_q;
  end

  // Lane registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      word_q  <= '0;
      shift_q <= '0;
      data_q  <= '0;
    end else begin
      word_q  <= word_d;
      shift_q <= shift_d;
      data_q  <= data_d;
    end
  end

  // Serial channel address and held conversion result
  always_comb begin
    mosi = serial_bit(word_q, cnt);
    data = data_q;
  end

  // Leading zero bits of the reading are shifted in but never published
  assign unused_shift_msbs = ^shift_d[WORD_W-1:DATA_W];

endmodule
`default_nettype wire

// File: rtl/daq_spi_frontend.sv
`default_nettype none
// ============================================================================
// Module      : daq_spi_frontend
// Description : SPI front end for two DACs and two ADCs sharing one chip
//               select, running back-to-back frames forever.
// Revision    : 1.0 - initial release
// ============================================================================
module daq_spi_frontend
  import daq_spi_pkg::*;
#(
  parameter logic CPOL  = 1'b1,
  parameter logic SS    = 1'b1,
  parameter int   BYTES = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  daq_spi_frontend_if.master        bus
);

  spi_frame_seq #(
    .CPOL  (CPOL),
    .SS    (SS),
    .BYTES (BYTES)
  ) u_seq (
    .clk   (clk),
    .reset (reset),
    .cnt   (bus.cnt),
    .ready (bus.ready),
    .ss    (bus.ss),
    .sclk  (bus.sclk)
  );

  // DAC clock is the inverse of the ADC clock
  always_comb begin
    bus.dac_sclk = ~bus.sclk;
  end

  spi_dac_ser u_dac_a (
    .clk   (clk),
    .reset (reset),
    .cnt   (bus.cnt),
    .pd    (bus.dac_pd),
    .data  (bus.dac_data_a),
    .mosi  (bus.dac_mosi_a)
  );

  spi_dac_ser u_dac_b (
    .clk   (clk),
    .reset (reset),
    .cnt   (bus.cnt),
    .pd    (bus.dac_pd),
    .data  (bus.dac_data_b),
    .mosi  (bus.dac_mosi_b)
  );

  spi_adc_ser #(.BYTES(BYTES)) u_adc_a (
    .clk     (clk),
    .reset   (reset),
    .cnt     (bus.cnt),
    .channel (bus.adc_channel),
    .miso    (bus.adc_miso_a),
    .mosi    (bus.adc_mosi_a),
    .data    (bus.adc_data_a)
  );

  spi_adc_ser #(.BYTES(BYTES)) u_adc_b (
    .clk     (clk),
    .reset   (reset),
    .cnt     (bus.cnt),
    .channel (bus.adc_channel),
    .miso    (bus.adc_miso_b),
    .mosi    (bus.adc_mosi_b),
    .data    (bus.adc_data_b)
  );

endmodule
`default_nettype wire

// File: tb/tb_daq_spi_frontend.sv
`default_nettype none
// ============================================================================
// Module      : tb_daq_spi_frontend
// Description : Self-checking bench for daq_spi_frontend: directed frame
//               table, randomized frames against a frame-level model, ready
//               period and mid-frame reset sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_daq_spi_frontend;

  localparam logic CPOL  = 1'b1;
  localparam logic SS    = 1'b1;
  localparam int   BYTES = 2;
  localparam int   P     = 16 * BYTES + 2;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;
  logic [11:0] exp_adc_a = '0;
  logic [11:0] exp_adc_b = '0;

  daq_spi_frontend_if bus ();

  daq_spi_frontend #(
    .CPOL  (CPOL),
    .SS    (SS),
    .BYTES (BYTES)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  pd;
    logic [11:0] da;
    logic [11:0] db;
    logic [2:0]  ch;
    logic [15:0] ma;
    logic [15:0] mb;
    bit          scramble;
    logic [15:0] exp_sa;
    logic [15:0] exp_sb;
    logic [15:0] exp_sc;
    logic [11:0] exp_ada;
    logic [11:0] exp_adb;
  } vec_t;

  vec_t vecs[4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full frame starting at phase 0. Inputs for the frame are applied
  // right after phase 0 is observed (they are the ones captured); with
  // scramble set the data inputs are randomized during the bit phases.
  task automatic run_frame(input logic [1:0] pd, input logic [11:0] da,
                           input logic [11:0] db, input logic [2:0] ch,
                           input logic [15:0] ma, input logic [15:0] mb,
                           input bit scramble,
                           output logic [15:0] sa, output logic [15:0] sb,
                           output logic [15:0] sca, output logic [15:0] scb);
    logic [15:0] wa, wb, wc;
    logic        es, es_n, ess;
    int          high_cnt;
    int          b;
    wa = {pd, da, 2'b00};
    wb = {pd, db, 2'b00};
    wc = {2'b00, ch, 11'b0};
    sa = '0; sb = '0; sca = '0; scb = '0;
    high_cnt = 0;
    for (int p = 0; p < P; p++) begin
      es   = (p >= 2 && (p % 2) == 1) ? !CPOL : CPOL;
      es_n = !es;
      ess  = (p == 0) ? SS : !SS;
      b    = (p >= 2) ? (p - 2) / 2 : 0;
      chk("cnt", 32'(bus.cnt), 32'(p));
      chk("ready", 32'(bus.ready), 32'(p == 0));
      chk("ss", 32'(bus.ss), 32'(ess));
      chk("sclk", 32'(bus.sclk), 32'(es));
      chk("dac_sclk", 32'(bus.dac_sclk), 32'(es_n));
      chk("adc_data_a", 32'(bus.adc_data_a), 32'(exp_adc_a));
      chk("adc_data_b", 32'(bus.adc_data_b), 32'(exp_adc_b));
      if (p >= 2) begin
        chk("mosi_bits", 32'({bus.dac_mosi_a, bus.dac_mosi_b, bus.adc_mosi_a, bus.adc_mosi_b}),
            32'({wa[15-b], wb[15-b], wc[15-b], wc[15-b]}));
        if ((p % 2) == 0) begin
          sa[15-b]  = bus.dac_mosi_a;
          sb[15-b]  = bus.dac_mosi_b;
          sca[15-b] = bus.adc_mosi_a;
          scb[15-b] = bus.adc_mosi_b;
        end
      end else begin
        chk("mosi_idle", 32'({bus.dac_mosi_a, bus.dac_mosi_b, bus.adc_mosi_a, bus.adc_mosi_b}), 32'(0));
      end
      if (bus.sclk == !CPOL) high_cnt++;
      if (p == 0) begin
        bus.dac_pd      = pd;
        bus.dac_data_a  = da;
        bus.dac_data_b  = db;
        bus.adc_channel = ch;
      end else if (scramble) begin
        bus.dac_pd      = 2'($urandom);
        bus.dac_data_a  = 12'($urandom);
        bus.dac_data_b  = 12'($urandom);
        bus.adc_channel = 3'($urandom);
      end
      if (p >= 2) begin
        bus.adc_miso_a = ma[15-b];
        bus.adc_miso_b = mb[15-b];
      end else begin
        bus.adc_miso_a = 1'($urandom);
        bus.adc_miso_b = 1'($urandom);
      end
      tick();
    end
    exp_adc_a = ma[11:0];
    exp_adc_b = mb[11:0];
    chk("sclk_pulses", 32'(high_cnt), 32'(16));
  endtask

  initial begin
    logic [15:0] sa, sb, sca, scb;
    logic [1:0]  pd;
    logic [11:0] da, db;
    logic [2:0]  ch;
    logic [15:0] ma, mb;
    int          n;

    vecs[0] = '{2'b01, 12'hA5C, 12'h123, 3'h1, 16'h0ABC, 16'hF123, 1'b1,
                16'h6970, 16'h448C, 16'h0800, 12'hABC, 12'h123};
    vecs[1] = '{2'b11, 12'hFFF, 12'h800, 3'h7, 16'h5FFF, 16'h0000, 1'b1,
                16'hFFFC, 16'hE000, 16'h3800, 12'hFFF, 12'h000};
    vecs[2] = '{2'b10, 12'h000, 12'hFFF, 3'h5, 16'h8001, 16'hFFFF, 1'b1,
                16'h8000, 16'hBFFC, 16'h2800, 12'h001, 12'hFFF};
    vecs[3] = '{2'b00, 12'h001, 12'h000, 3'h0, 16'h1234, 16'hAAAA, 1'b0,
                16'h0004, 16'h0000, 16'h0000, 12'h234, 12'hAAA};

    bus.dac_pd      = 2'b11;
    bus.dac_data_a  = 12'hFFF;
    bus.dac_data_b  = 12'hFFF;
    bus.adc_channel = 3'h7;
    bus.adc_miso_a  = 1'b1;
    bus.adc_miso_b  = 1'b1;

    // Reset state
    reset = 1'b1;
    repeat (3) tick();
    chk("rst_cnt", 32'(bus.cnt), 32'(0));
    chk("rst_ready", 32'(bus.ready), 32'(0));
    chk("rst_ss", 32'(bus.ss), 32'(SS));
    chk("rst_sclk", 32'(bus.sclk), 32'(CPOL));
    chk("rst_dac_sclk", 32'(bus.dac_sclk), 32'(!CPOL));
    chk("rst_mosi", 32'({bus.dac_mosi_a, bus.dac_mosi_b, bus.adc_mosi_a, bus.adc_mosi_b}), 32'(0));
    chk("rst_adc_a", 32'(bus.adc_data_a), 32'(0));
    chk("rst_adc_b", 32'(bus.adc_data_b), 32'(0));

    // Release: phase 0 for one cycle, then frames
    reset = 1'b0;
    #1;

    // Directed frame table
    for (int i = 0; i < 4; i++) begin
      run_frame(vecs[i].pd, vecs[i].da, vecs[i].db, vecs[i].ch, vecs[i].ma, vecs[i].mb,
                vecs[i].scramble, sa, sb, sca, scb);
      chk("tbl_dac_a_stream", 32'(sa), 32'(vecs[i].exp_sa));
      chk("tbl_dac_b_stream", 32'(sb), 32'(vecs[i].exp_sb));
      chk("tbl_adc_a_stream", 32'(sca), 32'(vecs[i].exp_sc));
      chk("tbl_adc_b_stream", 32'(scb), 32'(vecs[i].exp_sc));
      chk("tbl_adc_data_a", 32'(bus.adc_data_a), 32'(vecs[i].exp_ada));
      chk("tbl_adc_data_b", 32'(bus.adc_data_b), 32'(vecs[i].exp_adb));
    end

    // Ready period: from one strobe to the next
    bus.adc_miso_a = 1'b0;
    bus.adc_miso_b = 1'b0;
    n = 0;
    do begin
      tick();
      n++;
    end while (bus.ready !== 1'b1 && n < 100);
    chk("ready_period", 32'(n), 32'(P));
    exp_adc_a = '0;
    exp_adc_b = '0;

    // Randomized frames against the frame-level model
    for (int f = 0; f < 6; f++) begin
      pd = 2'($urandom);
      da = 12'($urandom);
      db = 12'($urandom);
      ch = 3'($urandom);
      ma = 16'($urandom);
      mb = 16'($urandom);
      run_frame(pd, da, db, ch, ma, mb, 1'b1, sa, sb, sca, scb);
      chk("rnd_dac_a_stream", 32'(sa), 32'({pd, da, 2'b00}));
      chk("rnd_dac_b_stream", 32'(sb), 32'({pd, db, 2'b00}));
      chk("rnd_adc_a_stream", 32'(sca), 32'({2'b00, ch, 11'b0}));
      chk("rnd_adc_data_a", 32'(bus.adc_data_a), 32'(ma[11:0]));
      chk("rnd_adc_data_b", 32'(bus.adc_data_b), 32'(mb[11:0]));
    end

    // Mid-frame reset at phase 20
    for (int p = 0; p < 20; p++) begin
      bus.dac_data_b = 12'($urandom);
      bus.adc_miso_a = 1'($urandom);
      bus.adc_miso_b = 1'($urandom);
      tick();
    end
    chk("abort_cnt_before", 32'(bus.cnt), 32'(20));
    reset = 1'b1;
    #1;
    chk("abort_ss", 32'(bus.ss), 32'(SS));
    chk("abort_sclk", 32'(bus.sclk), 32'(CPOL));
    chk("abort_cnt", 32'(bus.cnt), 32'(0));
    chk("abort_ready", 32'(bus.ready), 32'(0));
    chk("abort_adc_a", 32'(bus.adc_data_a), 32'(0));
    chk("abort_adc_b", 32'(bus.adc_data_b), 32'(0));
    tick();
    tick();
    chk("abort_hold_cnt", 32'(bus.cnt), 32'(0));
    chk("abort_hold_mosi", 32'({bus.dac_mosi_a, bus.dac_mosi_b, bus.adc_mosi_a, bus.adc_mosi_b}), 32'(0));
    reset = 1'b0;
    exp_adc_a = '0;
    exp_adc_b = '0;
    #1;
    run_frame(2'b01, 12'hA5C, 12'h3C3, 3'h1, 16'h0ABC, 16'h0555, 1'b1, sa, sb, sca, scb);
    chk("post_abort_dac_a_stream", 32'(sa), 32'(16'h6970));
    chk("post_abort_adc_data_a", 32'(bus.adc_data_a), 32'(12'hABC));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
